// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width and operand-loader state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 6;

  typedef enum logic [1:0] {
    S_A     = 2'b00,
    S_B     = 2'b01,
    S_READY = 2'b10
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer: the stable level follows raw only after DEBOUNCE_CYCLES
// consecutive mismatching samples; press pulses for one cycle on each accepted rise.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count_reg;
  logic          stable_reg;
  logic          prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= '0;
      stable_reg <= 1'b0;
      prev_reg   <= 1'b0;
    end else begin
      prev_reg <= stable_reg;
      if (raw != stable_reg) begin
        // The count saturates at LAST because reaching it flips the level.
        if (count_reg == LAST) begin
          stable_reg <= raw;
          count_reg  <= '0;
        end else begin
          count_reg <= count_reg + ONE;
        end
      end else begin
        count_reg <= '0;
      end
    end
  end

  assign stable = stable_reg;
  assign press  = stable_reg & ~prev_reg;

endmodule

// File: rtl/alu_operand_loader.sv
// Captures ALU operands A and B from the switches, one per debounced button press.
// Define ALU_OPLOAD_SYNC_EN to pass btn_in/sw_in through 2-flop synchronizers first.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int WIDTH           = ALU_WIDTH,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             btn_in,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             operands_valid,
  output logic [1:0]       step
);

  logic [WIDTH-1:0] sw_s;
  logic             btn_s;

`ifdef ALU_OPLOAD_SYNC_EN
  logic [1:0] btn_sync_reg;
  logic [WIDTH-1:0] sw_sync0_reg;
  logic [WIDTH-1:0] sw_sync1_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sync_reg <= 2'b00;
      sw_sync0_reg <= '0;
      sw_sync1_reg <= '0;
    end else begin
      btn_sync_reg <= {btn_sync_reg[0], btn_in};
      sw_sync0_reg <= sw_in;
      sw_sync1_reg <= sw_sync0_reg;
    end
  end

  assign btn_s = btn_sync_reg[1];
  assign sw_s  = sw_sync1_reg;
`else
  assign btn_s = btn_in;
  assign sw_s  = sw_in;
`endif

  logic btn_stable;
  logic btn_press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_s),
    .stable(btn_stable),
    .press (btn_press)
  );

  state_t           state_reg;
  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic             valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_A;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_A: begin
          if (btn_press) begin
            op_a_reg  <= sw_s;
            state_reg <= S_B;
            valid_reg <= 1'b0;
          end
        end
        S_B: begin
          if (btn_press) begin
            op_b_reg  <= sw_s;
            state_reg <= S_READY;
            valid_reg <= 1'b1;
          end
        end
        S_READY: begin
          // Reload A only; B is kept so the user can sweep A against a fixed B.
          if (btn_press) begin
            op_a_reg  <= sw_s;
            state_reg <= S_B;
            valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_A;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign op_a           = op_a_reg;
  assign op_b           = op_b_reg;
  assign operands_valid = valid_reg;
  assign step           = state_reg;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: directed steps then random button/switch/reset traffic.
module tb_alu_operand_loader;

  localparam int W = 6;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] sw_in = '0;
  logic         btn_in = 1'b0;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         operands_valid;
  logic [1:0]   step;

  alu_operand_loader #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sw_in         (sw_in),
    .btn_in        (btn_in),
    .op_a          (op_a),
    .op_b          (op_b),
    .operands_valid(operands_valid),
    .step          (step)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the button level is accepted once the samples since the
  // last acceptance (or reset) form an unbroken run of D opposite values.
  bit       m_level;
  bit       m_level_prev;
  bit       m_run[$];
  int       m_phase;   // 0: waiting for A, 1: waiting for B, 2: both held
  bit [W-1:0] m_a;
  bit [W-1:0] m_b;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit pressed;
    if (reset) begin
      m_level = 0; m_level_prev = 0; m_run.delete();
      m_phase = 0; m_a = '0; m_b = '0;
      return;
    end
    pressed = m_level && !m_level_prev;
    m_level_prev = m_level;
    if (btn_in == m_level) m_run.delete();
    else begin
      m_run.push_back(btn_in);
      if (m_run.size() == D) begin
        m_level = btn_in;
        m_run.delete();
      end
    end
    if (pressed) begin
      if (m_phase == 1) begin m_b = sw_in; m_phase = 2; end
      else begin m_a = sw_in; m_phase = 1; end
    end
  endtask

  task automatic model_check();
    check("op_a", op_a, m_a);
    check("op_b", op_b, m_b);
    check("valid", W'(operands_valid), W'(m_phase == 2));
    check("step", W'(step), W'(m_phase));
  endtask

  // One clock: drive inputs, take the edge, update the model, sample #1 later.
  task automatic cyc(input logic r, input logic b, input logic [W-1:0] s);
    reset = r; btn_in = b; sw_in = s;
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic press(input logic [W-1:0] s, input int hi, input int lo);
    for (int i = 0; i < hi; i++) cyc(1'b0, 1'b1, s);
    for (int i = 0; i < lo; i++) cyc(1'b0, 1'b0, s);
  endtask

  initial begin
    // Reset with the button held and all switches up.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 6'h3F);
      check("rst_op_a", op_a, '0);
      check("rst_step", W'(step), '0);
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 6'h3F);

    // First press: nothing at edge 4, op_a captured at edge 5.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 6'b101010);
    check("a_before_edge5", op_a, '0);
    cyc(1'b0, 1'b1, 6'b101010);
    check("a_at_edge5", op_a, 6'b101010);
    check("step_after_a", W'(step), W'(2'b01));
    press(6'b101010, 5, 10);

    press(6'b010101, 10, 10);
    check("b_capture", op_b, 6'b010101);
    check("valid_ready", W'(operands_valid), W'(1));
    check("step_ready", W'(step), W'(2'b10));

    // Glitch shorter than the debounce window.
    press(6'b111000, 3, 5);
    check("glitch_a", op_a, 6'b101010);
    check("glitch_b", op_b, 6'b010101);
    check("glitch_step", W'(step), W'(2'b10));

    // Reload A from READY.
    press(6'b001100, 10, 10);
    check("reload_a", op_a, 6'b001100);
    check("reload_b", op_b, 6'b010101);
    check("reload_valid", W'(operands_valid), W'(0));
    check("reload_step", W'(step), W'(2'b01));
    press(6'b010101, 10, 10);

    // Long hold with toggling switches: only the value at edge 5 is taken.
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b1, (i % 2 == 0) ? 6'h0F : 6'h30);
    check("hold_a", op_a, 6'h0F);
    check("hold_step", W'(step), W'(2'b01));
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 6'h3F);
    check("hold_release_a", op_a, 6'h0F);

    // Reset pulse mid-debounce restarts the full count.
    cyc(1'b0, 1'b1, 6'h33);
    cyc(1'b0, 1'b1, 6'h33);
    cyc(1'b1, 1'b1, 6'h33);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 6'h33);
    check("rstmid_no_capture", op_a, '0);
    cyc(1'b0, 1'b1, 6'h33);
    check("rstmid_capture", op_a, 6'h33);
    check("rstmid_step", W'(step), W'(2'b01));
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 6'h00);

    // Random traffic: button runs of varying length, random switches, rare resets.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        cyc(1'b1, 1'($urandom), W'($urandom));
      end else begin
        logic b;
        int len;
        b = 1'($urandom);
        len = $urandom_range(1, 8);
        for (int k = 0; k < len; k++) cyc(1'b0, b, W'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
